mem_access_unit: RTL and testbench

- MEM-stage load/store sequencer between the EX/MEM pipeline register (ALU result as address, store data) and the byte-addressed, big-endian data memory.
- Handles word, halfword and byte loads and stores, with sign or zero extension on loads.
- Sub-word stores use read-modify-write, because the memory only writes full words.
- Detects misaligned accesses and stalls the pipeline while the memory's read delay elapses.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer.
// Holds the access-size encoding, the FSM state encoding, the latched
// request record and the alignment check used when a request is accepted.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;  // 2'd3 behaves as a word too

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Any size with bit 1 set is a full-word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = a[0];
      default: r = (a != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering between a memory word and a pipeline value.
// Ports:
//   word_i   - word read from memory
//   addr_i   - byte offset within the word
//   size_i   - access size (byte/half/word)
//   sgn_i    - sign-extend the load result
//   wdata_i  - store data, right-justified
//   load_o   - selected lane, extended to 32 bits
//   store_o  - word_i with the addressed lane replaced by store data
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  // Byte lane 0 is the most significant byte, so the bit offset is (3-addr)*8.
  logic [4:0]  bsh;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign bsh  = {~addr_i, 3'b000};
  assign bsel = word_i[bsh +: 8];
  assign hsel = addr_i[1] ? word_i[15:0] : word_i[31:16];

  always_comb begin
    load_o  = word_i;
    store_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{sgn_i & bsel[7]}}, bsel};
        store_o = (word_i & ~(32'h0000_00FF << bsh)) | ({24'b0, wdata_i[7:0]} << bsh);
      end
      SZ_HALF: begin
        load_o  = {{16{sgn_i & hsel[15]}}, hsel};
        store_o = addr_i[1] ? {word_i[31:16], wdata_i[15:0]}
                            : {wdata_i[15:0], word_i[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer for a big-endian, word-write-only memory.
// Sub-word stores are done as read-modify-write; misaligned accesses are
// suppressed and flagged. The pipeline is stalled until the response cycle.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_*                 - request from EX/MEM (held while stall=1)
//   stall                 - freeze upstream stages
//   resp_valid/rdata      - one-cycle completion with extended load data
//   misaligned            - completion was a suppressed misaligned access
//   mem_addr/re/we/wdata  - word-aligned memory interface
//   mem_rdata             - memory read data, settles READ_LAT cycles after re
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] word_q, word_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mis_q, mis_d;

  logic [31:0] align_word, ld_val, st_word;

  // READ extends the live read word into the response register; WRITE merges
  // store data into the word captured at the end of READ.
  assign align_word = (state_q == ST_WRITE) ? word_q : mem_rdata;

  mem_lane_align u_align (
    .word_i  (align_word),
    .addr_i  (req_q.addr[1:0]),
    .size_i  (req_q.size),
    .sgn_i   (req_q.sgn),
    .wdata_i (req_q.wdata),
    .load_o  (ld_val),
    .store_o (st_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      word_q       <= word_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mis_q        <= mis_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    word_d       = word_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    mis_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = '{write: req_write, size: req_size, sgn: req_signed,
                    addr: req_addr, wdata: req_wdata};
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            mis_d        = 1'b1;
          end else if (req_write && is_word(req_size)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
            cnt_d   = 4'(READ_LAT - 1);
          end
        end
      end
      ST_READ: begin
        if (cnt_q == 4'd0) begin
          word_d = mem_rdata;
          if (req_q.write) begin
            state_d = ST_WRITE;
          end else begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_val;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WRITE: begin
        state_d      = ST_DONE;
        resp_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;  // ST_DONE
    endcase
  end

  assign stall      = req_valid & (state_q != ST_DONE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign misaligned = mis_q;
  assign mem_addr   = {req_q.addr[31:2], 2'b00};
  assign mem_re     = (state_q == ST_READ);
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_wdata  = mem_we ? st_word : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model whose read
// data is only valid in the last cycle of the read delay.
module tb_mem_access_unit;
  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        reset, init;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, misaligned, mem_re, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misaligned(misaligned), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:63];
  int re_cnt = 0;

  always @(posedge clk) begin
    if (init) begin
      mem[4] <= 32'h8899AABB;
      mem[8] <= 32'h00000000;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    re_cnt <= mem_re ? re_cnt + 1 : 0;
  end

  always_comb begin
    mem_rdata = 32'hBAD0BAD0;
    if (mem_re && re_cnt >= READ_LAT - 1) mem_rdata = mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request, holds it until the response, then releases it.
  task automatic op(input string tag, input logic w, input logic [1:0] sz,
                    input logic sg, input logic [31:0] a, input logic [31:0] wd,
                    input int e_lat, input logic [31:0] e_rd, input logic e_mis,
                    input int e_re, input int e_we, input int e_wecyc,
                    input logic [31:0] e_wd);
    int lat = -1, nre = 0, nwe = 0, nst = 0, wecyc = -1, bad = 0;
    logic [31:0] rd = 'x, wdat = 'x;
    logic mis = 'x;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    for (int cyc = 0; cyc < 40 && lat < 0; cyc++) begin
      @(negedge clk);
      if (stall) nst++;
      if (mem_re) nre++;
      if ((mem_re || mem_we) && mem_addr !== {a[31:2], 2'b00}) bad++;
      if (mem_we) begin nwe++; wecyc = cyc; wdat = mem_wdata; end
      if (resp_valid) begin lat = cyc; rd = resp_rdata; mis = misaligned; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".lat"},   32'(lat), 32'(e_lat));
    chk({tag, ".rdata"}, rd, e_rd);
    chk({tag, ".mis"},   {31'b0, mis}, {31'b0, e_mis});
    chk({tag, ".re"},    32'(nre), 32'(e_re));
    chk({tag, ".we"},    32'(nwe), 32'(e_we));
    chk({tag, ".stall"}, 32'(nst), 32'(e_lat));
    chk({tag, ".addr"},  32'(bad), 32'd0);
    if (e_we != 0) begin
      chk({tag, ".wecyc"}, 32'(wecyc), 32'(e_wecyc));
      chk({tag, ".wdata"}, wdat, e_wd);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, ".misaligned"}, {31'b0, misaligned}, 32'd0);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, ".mem_re"},     {31'b0, mem_re}, 32'd0);
    chk({tag, ".mem_we"},     {31'b0, mem_we}, 32'd0);
    chk({tag, ".mem_addr"},   mem_addr, 32'd0);
    chk({tag, ".mem_wdata"},  mem_wdata, 32'd0);
    chk({tag, ".stall"},      {31'b0, stall}, 32'd0);
  endtask

  initial begin
    int we_seen;
    reset = 1'b1; init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0; init = 1'b0;

    //  tag    w     size  sg    addr         wdata         lat rdata          mis re we wecyc wdata
    op("lb",   1'b0, 2'd0, 1'b1, 32'h11, 32'h0,          3, 32'hFFFFFF99, 1'b0, 2, 0, 0, 32'h0);
    op("lbu",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0,          3, 32'h00000099, 1'b0, 2, 0, 0, 32'h0);
    op("lh",   1'b0, 2'd1, 1'b1, 32'h12, 32'h0,          3, 32'hFFFFAABB, 1'b0, 2, 0, 0, 32'h0);
    op("lhu",  1'b0, 2'd1, 1'b0, 32'h10, 32'h0,          3, 32'h00008899, 1'b0, 2, 0, 0, 32'h0);
    op("sb",   1'b1, 2'd0, 1'b0, 32'h12, 32'h000000CC,   4, 32'h0,        1'b0, 2, 1, 3, 32'h8899CCBB);
    chk("sb.mem", mem[4], 32'h8899CCBB);
    op("lb0",  1'b0, 2'd0, 1'b1, 32'h10, 32'h0,          3, 32'hFFFFFF88, 1'b0, 2, 0, 0, 32'h0);
    op("sw",   1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF,   2, 32'h0,        1'b0, 0, 1, 1, 32'hDEADBEEF);
    op("lw",   1'b0, 2'd2, 1'b0, 32'h20, 32'h0,          3, 32'hDEADBEEF, 1'b0, 2, 0, 0, 32'h0);
    op("lh13", 1'b0, 2'd1, 1'b1, 32'h13, 32'h0,          1, 32'h0,        1'b1, 0, 0, 0, 32'h0);
    op("sw22", 1'b1, 2'd2, 1'b0, 32'h22, 32'h12345678,   1, 32'h0,        1'b1, 0, 0, 0, 32'h0);
    chk("mis.mem", mem[8], 32'hDEADBEEF);
    op("sh",   1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF1234,   4, 32'h0,        1'b0, 2, 1, 3, 32'hDEAD1234);
    op("lb23", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0,          3, 32'h00000034, 1'b0, 2, 0, 0, 32'h0);
    op("lw3",  1'b0, 2'd3, 1'b1, 32'h20, 32'h0,          3, 32'hDEAD1234, 1'b0, 2, 0, 0, 32'h0);

    // Reset during READ of a sub-word store: no write, everything idle.
    we_seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h00000011;
    @(negedge clk); if (mem_we) we_seen++;
    @(negedge clk); if (mem_we) we_seen++;
    chk("rst.in_read", {31'b0, mem_re}, 32'd1);
    #4; reset = 1'b1; req_valid = 1'b0;
    @(negedge clk); if (mem_we) we_seen++;
    chk_idle("rst");
    #4; reset = 1'b0;
    @(negedge clk); if (mem_we) we_seen++;
    chk("rst.we", 32'(we_seen), 32'd0);
    chk("rst.mem", mem[4], 32'h8899CCBB);
    op("sb_re", 1'b1, 2'd0, 1'b0, 32'h12, 32'h00000011, 4, 32'h0, 1'b0, 2, 1, 3, 32'h889911BB);
    chk("sb_re.mem", mem[4], 32'h889911BB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
